// File: rtl/fetch_pc_unit.sv
// Program counter and fetch control for the single-cycle core.
// Drives the instruction-memory address, forwards the fetched word to decode,
// selects the next PC, detects the halt sentinel and misaligned redirects,
// and counts retired instructions with a saturating counter.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0063,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic [31:0]      instr_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    ERR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [31:0]      eaddr_q, eaddr_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             fire;

  // Fetch-side combinational outputs; instr_out reads zero while reset is held
  // and the NOP bubble otherwise whenever nothing is presented to decode.
  always_comb begin
    fire     = (state_q == RUN) && !stall;
    pc_plus4 = pc_q + 32'd4;
    if (rst) begin
      instr_out = '0;
    end else if (fire) begin
      instr_out = instr_in;
    end else begin
      instr_out = NOP_INSTR;
    end
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state and next-PC selection; halt outranks any redirect, and a
  // misaligned redirect freezes the PC instead of retiring.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    err_d    = err_q;
    eaddr_d  = eaddr_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (fire) begin
          if (instr_in == HALT_INSTR) begin
            state_d  = HALT;
            halted_d = 1'b1;
            cnt_d    = cnt_inc;
          end else if (br_taken && (br_target[1:0] != 2'b00)) begin
            state_d = ERR;
            err_d   = 1'b1;
            eaddr_d = br_target;
          end else if (br_taken) begin
            pc_d  = br_target;
            cnt_d = cnt_inc;
          end else begin
            pc_d  = pc_plus4;
            cnt_d = cnt_inc;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC, counter and error registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      eaddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      eaddr_q  <= eaddr_d;
    end
  end

  assign pc_out       = pc_q;
  assign instr_valid  = fire;
  assign halted       = halted_q;
  assign misalign_err = err_q;
  assign err_addr     = eaddr_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios followed by random
// stall/redirect traffic, checked against a behavioural fetch model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0063;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_ERR  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic             br_taken = 1'b0;
  logic [31:0]      br_target = '0;
  logic [31:0]      instr_in;
  logic [31:0]      pc_out;
  logic [31:0]      pc_plus4;
  logic [31:0]      instr_out;
  logic             instr_valid;
  logic             halted;
  logic             misalign_err;
  logic [31:0]      err_addr;
  logic [CNT_W-1:0] retired_cnt;

  fetch_pc_unit #(
    .RESET_PC  (RESET_PC),
    .HALT_INSTR(HALT_INSTR),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .instr_in    (instr_in),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .halted      (halted),
    .misalign_err(misalign_err),
    .err_addr    (err_addr),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: 128 words at 0x000-0x1FC, a small addi window at the
  // top of the address space, HALT_INSTR everywhere else.
  logic [31:0] mem [0:127];

  function automatic logic [31:0] imem_read(input logic [31:0] a);
    if (a < 32'h200) return mem[a[8:2]];
    if (a >= 32'hFFFF_FFF0) return 32'h0010_0093;
    return HALT_INSTR;
  endfunction

  always_comb instr_in = imem_read(pc_out);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] instr;
    logic        halted;
    logic        err;
    logic [31:0] eaddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state.
  int          m_mode;
  logic [31:0] m_pc;
  int unsigned m_cnt;
  logic [31:0] m_eaddr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare whatever the stimulus side has queued against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus4", pc_plus4, e.pc4);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.valid});
        chk("instr_out", instr_out, e.instr);
        chk("halted", {31'b0, halted}, {31'b0, e.halted});
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, e.err});
        chk("err_addr", err_addr, e.eaddr);
        chk("retired_cnt", {{(32-CNT_W){1'b0}}, retired_cnt}, e.cnt);
      end
    end
  end

  task automatic push_exp(input logic [31:0] pc, input logic valid, input logic [31:0] instr,
                          input logic h, input logic er, input logic [31:0] ea, input int unsigned c);
    exp_t e;
    e.pc = pc; e.pc4 = pc + 32'd4; e.valid = valid; e.instr = instr;
    e.halted = h; e.err = er; e.eaddr = ea; e.cnt = c;
    q.push_back(e);
    ->chk_ev;
  endtask

  function automatic int unsigned bump(input int unsigned c);
    return (c == CNT_MAX) ? c : c + 1;
  endfunction

  // One cycle: drive inputs, queue the expected view of this cycle, then
  // apply the fetch rules to the model for the upcoming edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    logic [31:0] w;
    logic        v;
    @(negedge clk);
    stall = s; br_taken = b; br_target = t;
    #1;
    w = imem_read(m_pc);
    v = (m_mode == M_RUN) && !s;
    push_exp(m_pc, v, v ? w : NOP_INSTR, m_mode == M_HALT, m_mode == M_ERR, m_eaddr, m_cnt);
    if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (v) begin
      if (w == HALT_INSTR) begin
        m_mode = M_HALT;
        m_cnt  = bump(m_cnt);
      end else if (b && (t % 4 != 0)) begin
        m_mode  = M_ERR;
        m_eaddr = t;
      end else begin
        m_pc  = b ? t : m_pc + 32'd4;
        m_cnt = bump(m_cnt);
      end
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    push_exp(RESET_PC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 0);
    m_mode = M_BOOT; m_pc = RESET_PC; m_cnt = 0; m_eaddr = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_target();
    int unsigned r;
    logic [31:0] x;
    r = $urandom_range(0, 99);
    x = $urandom();
    if (r < 5)  return {x[31:2], 2'b00} | 32'(r % 3 + 1);
    if (r < 10) return 32'h0000_0300;
    if (r < 13) return 32'hFFFF_FFF8;
    if (r < 22) return m_pc;
    return {23'b0, x[8:2], 2'b00};
  endfunction

  initial begin
    logic [31:0] tmp;
    int          stuck;
    for (int i = 0; i < 128; i++) begin
      tmp = $urandom();
      mem[i] = {tmp[31:7], 7'h13};
    end
    mem[5] = HALT_INSTR;

    // Sequential fetch, redirect, stalled redirect, halt with redirect.
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'h40);
    step(0, 1, 32'h10);
    repeat (3) step(1, 1, 32'h80);
    step(0, 1, 32'h80);
    step(0, 1, 32'h14);
    step(0, 1, 32'h40);
    for (int i = 0; i < 10; i++) step(1'($urandom()), 1'($urandom()), $urandom());

    // Misaligned redirect, then reset out of ERR.
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h22);
    for (int i = 0; i < 5; i++) step(1'($urandom()), 1'($urandom()), $urandom());

    // Run off the end of mapped memory.
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h1F8);
    repeat (5) step(0, 0, 0);

    // Self-loop until the counter saturates, then wrap past the top of memory.
    do_reset();
    step(0, 0, 0);
    repeat (20) step(0, 1, 32'h0);
    step(0, 1, 32'hFFFF_FFF8);
    repeat (4) step(0, 0, 0);

    // Random traffic with periodic resets.
    do_reset();
    stuck = 0;
    for (int i = 0; i < 1500; i++) begin
      if (stuck > 4 || $urandom_range(0, 199) == 0) begin
        do_reset();
        stuck = 0;
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, pick_target());
      if (m_mode == M_HALT || m_mode == M_ERR) stuck++;
    end

    @(negedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and fetch-control stage sitting directly upstream of the instruction memory in the single-cycle core.
- Drives the instruction-memory word address, receives the fetched instruction combinationally and forwards it to decode with a valid flag.
- Selects the next PC: sequential, branch/jump redirect or stall hold.
- Detects the halt sentinel and misaligned redirect targets, and counts retired instructions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_INSTR, 32'h00000063, instruction word treated as program end; it is also the word instruction memory returns for out-of-range addresses.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the current PC; no retire this cycle.
- br_taken  in  1  redirect request from execute for the current instruction.
- br_target  in  32  redirect target address (branch, JAL or JALR result).
- instr_in  in  32  instruction from instruction memory for pc_out.
- pc_out  out  32  current PC, drives the instruction-memory address.
- pc_plus4  out  32  pc_out+4 modulo 2^32, used for link-register writeback.
- instr_out  out  32  instruction forwarded to decode.
- instr_valid  out  1  instr_out is valid and retires at the next edge.
- halted  out  1  halt sentinel has retired.
- misalign_err  out  1  redirect to a non-word-aligned target was seen.
- err_addr  out  32  offending target captured at the error.
- retired_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (rst high, asynchronous):
  - pc_out = RESET_PC; state = BOOT.
  - halted = 0, misalign_err = 0, err_addr = 0, retired_cnt = 0.
  - instr_valid = 0, instr_out = 0.
- States:
  - BOOT: single cycle after reset release; instr_valid = 0; pc held; unconditionally goes to RUN on the next edge.
  - RUN: normal fetch.
  - HALT: terminal until reset.
  - ERR: terminal until reset.
- Combinational outputs:
  - instr_valid = (state==RUN) && !stall.
  - instr_out = instr_in when instr_valid, else 32'h00000013 (NOP).
  - pc_plus4 = pc_out + 4 in all states.
- RUN edge actions when instr_valid is 1, evaluated in this priority order:
  1. instr_in == HALT_INSTR: go to HALT; halted = 1; pc held; retired_cnt +1. Any br_taken is ignored.
  2. br_taken && br_target[1:0] != 0: go to ERR; misalign_err = 1; err_addr = br_target; pc held; no retire.
  3. br_taken: pc = br_target; retired_cnt +1.
  4. Otherwise: pc = pc_out + 4, wrapping 32'hFFFFFFFC -> 0; retired_cnt +1.
- RUN with stall = 1:
  - pc, counter and state unchanged.
  - br_taken is ignored; execute re-presents it when the stall drops.
- HALT and ERR:
  - pc, counter, err_addr and flags frozen.
  - stall, br_taken and instr_in are ignored; instr_valid = 0.
- Zero-latency fetch: pc_out changes only on clock edges; instr_in for the new PC is consumed in the same cycle.
- Counter:
  - Saturates at 2^CNT_W-1; no wrap.
  - It counts one per retired instruction, including the halt sentinel.
- Redirect to the current PC (self-loop) with an instruction other than HALT_INSTR is legal and loops indefinitely.
- Reset asserted mid-operation (any state) forces the reset values immediately, without waiting for a clock edge.
- A redirect into an unmapped instruction-memory region fetches HALT_INSTR and halts normally.

Test Plan:
- Reset with RESET_PC=0, then release; IMEM holds addi words -> BOOT cycle has instr_valid=0; pc_out steps 0,4,8,12 on the following edges; retired_cnt=3 after three RUN edges.
- At pc=8, br_taken=1, br_target=0x40 -> next pc_out=0x40; retired_cnt increments by 1; pc_plus4 showed 0xC during the redirect cycle.
- stall=1 for 3 cycles at pc=0x10, with br_taken=1 and br_target=0x80 held -> pc_out stays 0x10; instr_valid=0; count unchanged; redirect occurs on the first edge after stall drops.
- Instruction 32'h00000063 at pc=0x14 with br_taken=1 -> halted=1; pc_out remains 0x14; retired_cnt +1; later stall and br_taken toggles have no effect.
- br_taken=1, br_target=0x22 -> misalign_err=1; err_addr=0x22; pc held; no retire; asynchronous rst pulse mid-cycle clears everything with pc_out=RESET_PC before the next edge.
- Straight-line run from pc=0x1F8 past the end of the instruction-memory range -> memory returns HALT_INSTR at 0x200; halted=1 with pc_out=0x200; retired_cnt=3.
